// File: rtl/hk_readback_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hk_readback_ctrl
// Description : Housekeeper readback controller. Meters a programmed number of
//               sfifo bytes toward the ft245sff write side, flipping the FT245
//               FSM into write mode for the duration of the burst.
//               Optional inactivity timeout: define HK_RDBK_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module hk_readback_ctrl #(
    parameter logic [23:0] ADDR_COUNT  = 24'h000003,
    parameter int unsigned TURN_CYCLES = 2
`ifdef HK_RDBK_TIMEOUT_EN
    ,
    parameter logic [23:0] ADDR_TMO    = 24'h000004,
    parameter int unsigned TMO_WIDTH   = 24
`endif
) (
    input  logic        Clk,
    input  logic        ARstn,
    input  logic        CfgValid,
    input  logic [23:0] CfgAddr,
    input  logic [31:0] CfgData,
    input  logic        FifoEmpty,
    input  logic [7:0]  FifoRData,
    output logic        FifoRen,
    output logic [7:0]  WrData,
    input  logic        RdyWr,
    output logic        RWn,
    output logic        Busy,
    output logic [31:0] Remaining,
    output logic        Done,
    output logic        TimedOut
);

    localparam int unsigned TURN_W = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_TURN = 2'd1,
        S_XFER = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [TURN_W-1:0]  turn_q, turn_d;
    logic [31:0]        rem_q, rem_d;
    logic               rwn_q, busy_q, done_q, done_d, timedout_q;

    logic               w_cnt_wr;
    logic               w_cnt_zero;
    logic               w_ren;
    logic               w_tmo_hit;

    assign w_cnt_wr   = CfgValid && (CfgAddr == ADDR_COUNT);
    assign w_cnt_zero = (CfgData == 32'd0);
    assign w_ren      = (state_q == S_XFER) && !FifoEmpty && RdyWr && (rem_q != 32'd0);

`ifdef HK_RDBK_TIMEOUT_EN
    logic [TMO_WIDTH-1:0] tmo_reg_q, tmo_cnt_q;
    logic                 w_tmo_wr;

    assign w_tmo_wr  = CfgValid && (CfgAddr == ADDR_TMO);
    // Any config write in the same cycle restarts the inactivity window instead.
    assign w_tmo_hit = (state_q == S_XFER) && !w_ren && !w_cnt_wr && !w_tmo_wr
                       && (tmo_reg_q != '0)
                       && ((tmo_cnt_q + TMO_WIDTH'(1)) == tmo_reg_q);

    always_ff @(posedge Clk or negedge ARstn) begin
        if (!ARstn) begin
            tmo_reg_q <= '0;
            tmo_cnt_q <= '0;
        end else begin
            if (w_tmo_wr) begin
                tmo_reg_q <= CfgData[TMO_WIDTH-1:0];
            end
            if (w_tmo_wr || w_cnt_wr || w_ren || w_tmo_hit) begin
                tmo_cnt_q <= '0;
            end else if ((state_q == S_XFER) && (tmo_reg_q != '0)) begin
                tmo_cnt_q <= tmo_cnt_q + TMO_WIDTH'(1);
            end
        end
    end
`else
    assign w_tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        turn_d  = turn_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (w_cnt_wr) begin
                    rem_d = CfgData;
                    if (!w_cnt_zero) begin
                        state_d = S_TURN;
                        turn_d  = '0;
                    end
                end
            end
            S_TURN: begin
                if (w_cnt_wr && w_cnt_zero) begin
                    rem_d   = 32'd0;
                    state_d = S_IDLE;
                end else begin
                    if (w_cnt_wr) begin
                        rem_d = CfgData;
                    end
                    if (turn_q == TURN_W'(TURN_CYCLES - 1)) begin
                        state_d = S_XFER;
                    end else begin
                        turn_d = turn_q + TURN_W'(1);
                    end
                end
            end
            S_XFER: begin
                // A reload overrides the decrement of a read in the same cycle.
                if (w_cnt_wr && w_cnt_zero) begin
                    rem_d   = 32'd0;
                    state_d = S_IDLE;
                end else if (w_cnt_wr) begin
                    rem_d = CfgData;
                end else if (w_ren) begin
                    rem_d = rem_q - 32'd1;
                    if (rem_q == 32'd1) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end else if (w_tmo_hit) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge ARstn) begin
        if (!ARstn) begin
            state_q    <= S_IDLE;
            turn_q     <= '0;
            rem_q      <= 32'd0;
            rwn_q      <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            timedout_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            turn_q     <= turn_d;
            rem_q      <= rem_d;
            rwn_q      <= (state_d == S_IDLE);
            busy_q     <= (state_d != S_IDLE);
            done_q     <= done_d;
            timedout_q <= w_tmo_hit;
        end
    end

    assign FifoRen   = w_ren;
    assign WrData    = FifoRData;
    assign RWn       = rwn_q;
    assign Busy      = busy_q;
    assign Remaining = rem_q;
    assign Done      = done_q;
    assign TimedOut  = timedout_q;

endmodule
`default_nettype wire

// File: tb/tb_hk_readback_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hk_readback_ctrl
// Description : Self-checking bench for hk_readback_ctrl: directed scenarios
//               plus randomized traffic against a behavioural burst model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hk_readback_ctrl;

    localparam int TURN = 2;
`ifdef HK_RDBK_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        ARstn = 1'b0;
    logic        CfgValid = 1'b0;
    logic [23:0] CfgAddr = 24'd0;
    logic [31:0] CfgData = 32'd0;
    logic        FifoEmpty = 1'b1;
    logic [7:0]  FifoRData = 8'd0;
    logic        RdyWr = 1'b0;
    logic        FifoRen, RWn, Busy, Done, TimedOut;
    logic [7:0]  WrData;
    logic [31:0] Remaining;

    always #5 Clk = ~Clk;

    hk_readback_ctrl dut (
        .Clk       (Clk),
        .ARstn     (ARstn),
        .CfgValid  (CfgValid),
        .CfgAddr   (CfgAddr),
        .CfgData   (CfgData),
        .FifoEmpty (FifoEmpty),
        .FifoRData (FifoRData),
        .FifoRen   (FifoRen),
        .WrData    (WrData),
        .RdyWr     (RdyWr),
        .RWn       (RWn),
        .Busy      (Busy),
        .Remaining (Remaining),
        .Done      (Done),
        .TimedOut  (TimedOut)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model: phase 0 idle, 1 turnaround, 2 transfer.
    byte unsigned fq[$];
    int           m_ph, m_turn_left, m_quiet;
    longint       m_rem;
    longint       m_tmo;
    bit           m_done, m_to;

    int cyc, n_rd, n_done, n_to, first_rd, last_rd, to_cyc, w;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_ph = 0; m_turn_left = 0; m_quiet = 0; m_rem = 0; m_tmo = 0;
        m_done = 1'b0; m_to = 1'b0;
    endtask

    task automatic clr_obs();
        n_rd = 0; n_done = 0; n_to = 0; first_rd = -1; last_rd = -1; to_cyc = -1;
    endtask

    // One clock: drive inputs, compare at the falling edge, advance the model.
    task automatic step(input bit cv, input logic [23:0] ca, input logic [31:0] cd,
                        input bit rdy, input int push);
        bit ren, cw, tw;
        CfgValid = cv; CfgAddr = ca; CfgData = cd; RdyWr = rdy;
        for (int i = 0; i < push; i++)
            if (fq.size() < 40) fq.push_back(8'($urandom));
        FifoEmpty = (fq.size() == 0);
        FifoRData = FifoEmpty ? 8'($urandom) : fq[0];
        @(negedge Clk);
        ren = (m_ph == 2) && !FifoEmpty && rdy && (m_rem != 0);
        chk("FifoRen", FifoRen, ren);
        if (ren) chk("WrData", WrData, fq[0]);
        chk("RWn", RWn, m_ph == 0);
        chk("Busy", Busy, m_ph != 0);
        chk("Remaining", Remaining, m_rem[31:0]);
        chk("Done", Done, m_done);
        chk("TimedOut", TimedOut, m_to);
        if (FifoRen) begin
            n_rd++; last_rd = cyc;
            if (first_rd < 0) first_rd = cyc;
        end
        if (Done) n_done++;
        if (TimedOut) begin n_to++; to_cyc = cyc; end

        cw = cv && (ca == 24'h000003);
        tw = TMO_EN && cv && (ca == 24'h000004);
        m_done = 1'b0; m_to = 1'b0;
        if (ren) void'(fq.pop_front());
        if (m_ph == 0) begin
            if (cw) begin
                m_rem = cd;
                if (cd != 0) begin m_ph = 1; m_turn_left = TURN; m_quiet = 0; end
            end
        end else if (cw && cd == 0) begin
            m_rem = 0; m_ph = 0;
        end else begin
            if (m_ph == 1) begin
                m_turn_left--;
                if (m_turn_left == 0) m_ph = 2;
            end else if (ren) begin
                m_quiet = 0;
                if (!cw) begin
                    m_rem--;
                    if (m_rem == 0) begin m_ph = 0; m_done = 1'b1; end
                end
            end else if (!cw && !tw && m_tmo != 0) begin
                m_quiet++;
                if (m_quiet == m_tmo) begin m_ph = 0; m_to = 1'b1; end
            end
            if (cw) begin m_rem = cd; m_quiet = 0; end
        end
        if (tw) begin m_tmo = cd[23:0]; m_quiet = 0; end
        @(posedge Clk);
        #1;
        cyc++;
    endtask

    task automatic idle_steps(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b0, 24'd0, 32'd0, rdy, 0);
    endtask

    bit          r_cv;
    int          r_sel;
    logic [23:0] r_ca;
    logic [31:0] r_cd;

    initial begin
        model_reset();
        clr_obs();
        cyc = 0;
        @(posedge Clk);
        #1;
        chk("reset_RWn", RWn, 1'b1);
        chk("reset_Busy", Busy, 1'b0);
        chk("reset_Remaining", Remaining, 32'd0);
        chk("reset_FifoRen", FifoRen, 1'b0);
        chk("reset_Done", Done, 1'b0);
        chk("reset_TimedOut", TimedOut, 1'b0);
        ARstn = 1'b1;
        idle_steps(2, 1'b1);

        // Plain burst of four.
        clr_obs(); w = cyc;
        step(1'b1, 24'h3, 32'd4, 1'b1, 4);
        chk("t1_rwn_low", RWn, 1'b0);
        idle_steps(8, 1'b1);
        chk("t1_first_read", first_rd - w, 3);
        chk("t1_reads", n_rd, 4);
        chk("t1_last_read", last_rd - w, 6);
        chk("t1_done", n_done, 1);
        chk("t1_remaining", Remaining, 32'd0);
        chk("t1_rwn_high", RWn, 1'b1);

        // Ready toggling.
        clr_obs(); fq.delete(); w = cyc;
        step(1'b1, 24'h3, 32'd3, 1'b1, 5);
        idle_steps(2, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 24'd0, 32'd0, (i % 2) == 0, 0);
        idle_steps(2, 1'b1);
        chk("t2_reads", n_rd, 3);
        chk("t2_done", n_done, 1);

        // Inactivity timeout.
        clr_obs(); fq.delete();
        step(1'b1, 24'h4, 32'd10, 1'b1, 0);
        step(1'b1, 24'h3, 32'd5, 1'b1, 2);
        idle_steps(20, 1'b1);
        chk("t3_reads", n_rd, 2);
        chk("t3_done", n_done, 0);
        chk("t3_remaining", Remaining, 32'd3);
`ifdef HK_RDBK_TIMEOUT_EN
        chk("t3_timeouts", n_to, 1);
        chk("t3_to_delay", to_cyc - last_rd, 11);
        chk("t3_rwn", RWn, 1'b1);
`else
        chk("t3_timeouts", n_to, 0);
        chk("t3_still_busy", Busy, 1'b1);
        step(1'b1, 24'h3, 32'd0, 1'b1, 0);
`endif

        // Abort after three reads.
        clr_obs(); fq.delete();
        step(1'b1, 24'h3, 32'd8, 1'b1, 8);
        idle_steps(5, 1'b1);
        step(1'b1, 24'h3, 32'd0, 1'b0, 0);
        chk("t4_busy", Busy, 1'b0);
        idle_steps(3, 1'b1);
        chk("t4_reads", n_rd, 3);
        chk("t4_remaining", Remaining, 32'd0);
        chk("t4_done", n_done, 0);
        chk("t4_timeouts", n_to, 0);

        // Reload colliding with a read.
        clr_obs(); fq.delete();
        step(1'b1, 24'h3, 32'd8, 1'b1, 8);
        idle_steps(2, 1'b1);
        step(1'b1, 24'h3, 32'd2, 1'b1, 0);
        chk("t5_reload", Remaining, 32'd2);
        idle_steps(4, 1'b1);
        chk("t5_reads", n_rd, 3);
        chk("t5_done", n_done, 1);
        chk("t5_remaining", Remaining, 32'd0);

        // Asynchronous reset mid-transfer.
        clr_obs(); fq.delete();
        step(1'b1, 24'h3, 32'd5, 1'b1, 0);
        idle_steps(4, 1'b1);
        chk("t6_pre_rem", Remaining, 32'd5);
        ARstn = 1'b0;
        #1;
        chk("t6_RWn", RWn, 1'b1);
        chk("t6_Busy", Busy, 1'b0);
        chk("t6_Remaining", Remaining, 32'd0);
        chk("t6_FifoRen", FifoRen, 1'b0);
        chk("t6_Done", Done, 1'b0);
        chk("t6_TimedOut", TimedOut, 1'b0);
        model_reset();
        @(posedge Clk);
        #1;
        ARstn = 1'b1;
        clr_obs();
        idle_steps(5, 1'b1);
        chk("t6_no_done", n_done, 0);
        chk("t6_no_timeout", n_to, 0);

        // Randomized traffic.
        for (int k = 0; k < 4000; k++) begin
            r_cv  = ($urandom_range(0, 99) < 8);
            r_sel = $urandom_range(0, 9);
            r_ca  = (r_sel < 6) ? 24'h3 : (r_sel < 8) ? 24'h4 : 24'($urandom_range(0, 15));
            if (r_ca == 24'h4) r_cd = $urandom_range(0, 12);
            else r_cd = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom_range(1, 10);
            step(r_cv, r_ca, r_cd, $urandom_range(0, 3) != 0, $urandom_range(0, 1));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
